multi_edge_detector: RTL and testbench
======================================

Name: multi_edge_detector

Overview:
Parametrised, multi-channel successor to the single-channel negative-edge detector. Each channel synchronises an asynchronous input and glitch-filters it. It then detects rising, falling or both edges according to a shared mode, per-channel sticky flags and saturating event counters. Sits between raw external/peripheral lines and control logic that needs clean one-cycle edge pulses plus event bookkeeping.

Parameters:
CH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_CNT, 3, consecutive cycles a new level must persist before acceptance (>=1)
CNT_W, 8, width of each per-channel event counter (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
signal  input  CH  raw asynchronous inputs, bit i = channel i
mode  input  2  00 rising, 01 falling, 10 both, 11 detection disabled
clr  input  CH  synchronous per-channel clear of sticky flag and counter
edge_detect  output  CH  one-cycle pulse per qualifying edge
edge_sticky  output  CH  latched "edge seen" flag
edge_count  output  CH*CNT_W  per-channel event counts, channel i at [i*CNT_W +: CNT_W]
level  output  CH  filtered, synchronised level

Behaviour:
- Reset: asynchronous on rst_n low. Immediately clears synchroniser flops, filter counters, level, edge_detect, edge_sticky and edge_count to 0. Reset asserted mid-filter discards the pending candidate.
- Synchroniser: SYNC_STAGES-flop chain per channel. sync_out = last stage.
- Filter, per channel, two states:
  - STABLE: sync_out == level, cnt = 0.
  - PENDING: sync_out != level.
  - On each edge where sync_out != level: if cnt == FILT_CNT-1, then level <= sync_out, cnt <= 0 and the edge is raised; otherwise cnt <= cnt+1.
  - On an edge where sync_out == level: cnt <= 0 (glitch rejected).
  - Counter width is clog2(FILT_CNT), minimum 1.
- Latency: input stable before edge t0 gives level/edge_detect update at edge t0 + SYNC_STAGES + FILT_CNT - 1 (defaults: 4 cycles). A pulse is rejected if sync_out holds it for fewer than FILT_CNT consecutive compare cycles.
- Edge qualification:
  - Rise = level 0->1; fall = level 1->0.
  - edge_detect[i] is registered, high exactly one cycle on the edge level changes, if mode permits.
  - mode is sampled on that same edge; changes apply to the next transition.
  - mode 11: no pulses, sticky or count updates. level still tracks.
- Sticky: set when edge_detect[i] is set. Cleared by clr[i]. Simultaneous edge and clr leaves it at 1 (set wins).
- Counter: +1 per qualifying edge, saturating at 2^CNT_W-1 (no wrap). clr[i] zeroes it. Simultaneous edge and clr gives 1.
- Channels are fully independent. Simultaneous edges on several channels each pulse in the same cycle.
- A channel already high at reset release produces a rising edge after the normal latency, since level resets to 0.

Test Plan:
(clk period 10 ns, rising edges at 5, 15, 25, …; default parameters unless stated)
1. rst_n=0 until 2, mode=00, signal[0] 0->1 at 12 -> edge_detect[0] high 55–65 only; level[0]=1 from 55; edge_sticky[0]=1; count0=1; other channels all 0.
2. mode=01, signal[0] 1->0 at 102 -> pulse 145–155, count0=2. Repeat the rise/fall with mode=00 -> level toggles, no falling pulse, count unchanged.
3. signal[1] high 202–222 -> no pulse, level[1] stays 0. Then signal[1] high 302–332 -> pulse at 345; subsequent fall (mode=00) gives no pulse.
4. CNT_W=2 instance, mode=10, five filtered transitions on channel 2 -> five pulses; edge_count ch2 saturates at 3 and holds.
5. clr[0] asserted in the same cycle as a channel-0 edge_detect -> edge_sticky[0]=1, count0=1 next cycle. clr[0] alone next cycle -> sticky 0, count 0.
6. rst_n pulsed low at 217 while channel 3 is PENDING -> all outputs 0 before 220; with signal[3] low after release, no pulse ever; with signal[3] high, a rising pulse appears 4 cycles after the first post-reset edge.

Source files
------------

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel synchroniser, glitch filter and edge
// qualifier with sticky flags and saturating event counters.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   signal[CH]   raw asynchronous inputs, bit i = channel i
//   mode[2]      00 rising, 01 falling, 10 both, 11 detection disabled
//   clr[CH]      synchronous per-channel clear of sticky flag and counter
//   edge_detect  one-cycle pulse per qualifying edge (registered)
//   edge_sticky  latched edge-seen flag (registered)
//   edge_count   per-channel saturating counts, channel i at [i*CNT_W +: CNT_W]
//   level        filtered, synchronised level (registered)
module multi_edge_detector #(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CNT    = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       signal,
    input  logic [1:0]          mode,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       edge_detect,
    output logic [CH-1:0]       edge_sticky,
    output logic [CH*CNT_W-1:0] edge_count,
    output logic [CH-1:0]       level
);

    localparam int unsigned FILT_W = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CNT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    logic [CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CH-1:0][FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
    logic [CH-1:0]                  level_q, level_d;
    logic [CH-1:0]                  edge_detect_q, edge_detect_d;
    logic [CH-1:0]                  edge_sticky_q, edge_sticky_d;
    logic [CH-1:0][CNT_W-1:0]       count_q, count_d;

    logic [CH-1:0] sync_out;
    logic [CH-1:0] level_change;

    // Synchroniser output is the oldest stage of each chain.
    always_comb begin
        sync_out = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Next-state logic for all channels.
    always_comb begin
        sync_d        = sync_q;
        filt_cnt_d    = filt_cnt_q;
        level_d       = level_q;
        edge_detect_d = '0;
        edge_sticky_d = edge_sticky_q;
        count_d       = count_q;
        level_change  = '0;

        for (int unsigned i = 0; i < CH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], signal[i]};

            // A new level is accepted only after FILT_CNT consecutive mismatches.
            if (sync_out[i] != level_q[i]) begin
                if (filt_cnt_q[i] == FILT_LAST) begin
                    level_d[i]      = sync_out[i];
                    filt_cnt_d[i]   = '0;
                    level_change[i] = 1'b1;
                end else begin
                    filt_cnt_d[i] = filt_cnt_q[i] + FILT_W'(1);
                end
            end else begin
                filt_cnt_d[i] = '0;
            end

            // New level equals sync_out, so sync_out=1 means a rise.
            if (level_change[i]) begin
                unique case (mode)
                    MODE_RISE: edge_detect_d[i] = sync_out[i];
                    MODE_FALL: edge_detect_d[i] = ~sync_out[i];
                    MODE_BOTH: edge_detect_d[i] = 1'b1;
                    default:   edge_detect_d[i] = 1'b0;
                endcase
            end

            // Bookkeeping follows the registered pulse; a pulse beats clr.
            edge_sticky_d[i] = edge_detect_q[i] | (edge_sticky_q[i] & ~clr[i]);

            if (clr[i]) begin
                count_d[i] = CNT_W'(edge_detect_q[i]);
            end else if (edge_detect_q[i] && (count_q[i] != CNT_MAX)) begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            filt_cnt_q    <= '0;
            level_q       <= '0;
            edge_detect_q <= '0;
            edge_sticky_q <= '0;
            count_q       <= '0;
        end else begin
            sync_q        <= sync_d;
            filt_cnt_q    <= filt_cnt_d;
            level_q       <= level_d;
            edge_detect_q <= edge_detect_d;
            edge_sticky_q <= edge_sticky_d;
            count_q       <= count_d;
        end
    end

    assign edge_detect = edge_detect_q;
    assign edge_sticky = edge_sticky_q;
    assign edge_count  = count_q;
    assign level       = level_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Testbench for multi_edge_detector: directed stimulus pushes expected pulse
// events into a queue; a monitor pops them whenever edge_detect fires.
module tb_multi_edge_detector;

    logic        clk;
    logic        rst_n;
    logic [3:0]  signal;
    logic [1:0]  mode;
    logic [3:0]  clr;
    logic [3:0]  edge_detect, edge_sticky, level;
    logic [31:0] edge_count;
    logic [3:0]  ed2, st2, lv2;
    logic [7:0]  ec2;

    multi_edge_detector u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal      (signal),
        .mode        (mode),
        .clr         (clr),
        .edge_detect (edge_detect),
        .edge_sticky (edge_sticky),
        .edge_count  (edge_count),
        .level       (level)
    );

    // Narrow-counter instance to exercise saturation.
    multi_edge_detector #(.CNT_W(2)) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal      (signal),
        .mode        (mode),
        .clr         (clr),
        .edge_detect (ed2),
        .edge_sticky (st2),
        .edge_count  (ec2),
        .level       (lv2)
    );

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_pulse(input logic [3:0] mask);
        exp_t e;
        e.cyc  = cyc + 5;
        e.mask = mask;
        exp_q.push_back(e);
    endtask

    // Monitor: every observed pulse must match the next expected event.
    always @(negedge clk) begin
        if (rst_n && (edge_detect != 4'b0)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(edge_detect), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_mask", 32'(edge_detect), 32'(e.mask));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        signal = 4'b0;
        mode   = 2'b00;
        clr    = 4'b0;

        // Reset state
        tick(1);
        chk("rst_edge", 32'(edge_detect), 32'h0);
        chk("rst_sticky", 32'(edge_sticky), 32'h0);
        chk("rst_count", edge_count, 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Rising edge on channel 0
        signal[0] = 1'b1; expect_pulse(4'b0001);
        tick(8);
        chk("t1_level", 32'(level), 32'h1);
        chk("t1_sticky", 32'(edge_sticky), 32'h1);
        chk("t1_count", edge_count, 32'h1);

        // Falling edge in falling mode, then rise/fall in rising mode
        mode = 2'b01;
        signal[0] = 1'b0; expect_pulse(4'b0001);
        tick(8);
        chk("t2_fall_level", 32'(level), 32'h0);
        chk("t2_fall_count", edge_count, 32'h2);
        mode = 2'b00;
        signal[0] = 1'b1; expect_pulse(4'b0001);
        tick(8);
        chk("t2_rise_level", 32'(level), 32'h1);
        chk("t2_rise_count", edge_count, 32'h3);
        signal[0] = 1'b0;
        tick(8);
        chk("t2_nofall_level", 32'(level), 32'h0);
        chk("t2_nofall_count", edge_count, 32'h3);

        // Glitch rejection on channel 1, then a just-long-enough pulse
        signal[1] = 1'b1;
        tick(2);
        signal[1] = 1'b0;
        tick(8);
        chk("t3_glitch_level", 32'(level), 32'h0);
        chk("t3_glitch_count", edge_count, 32'h3);
        signal[1] = 1'b1; expect_pulse(4'b0010);
        tick(3);
        signal[1] = 1'b0;
        tick(10);
        chk("t3_level", 32'(level), 32'h0);
        chk("t3_count", edge_count, 32'h0103);

        // Both-edge mode, five transitions on channel 2, narrow counter saturates
        mode = 2'b10;
        for (int k = 0; k < 5; k++) begin
            signal[2] = ~signal[2]; expect_pulse(4'b0100);
            tick(8);
            if (k == 2) chk("t4_sat_reach", 32'(ec2[5:4]), 32'h3);
        end
        chk("t4_count", edge_count, 32'h0005_0103);
        chk("t4_count_narrow", 32'(ec2), 32'h37);
        chk("t4_sticky", 32'(edge_sticky), 32'h7);

        // clr coinciding with a pulse, then clr alone
        signal[0] = 1'b1; expect_pulse(4'b0001);
        tick(5);
        clr = 4'b0001;
        tick(1);
        chk("t5_sticky_setwins", 32'(edge_sticky), 32'h7);
        chk("t5_count_one", edge_count, 32'h0005_0101);
        tick(1);
        chk("t5_sticky_clr", 32'(edge_sticky), 32'h6);
        chk("t5_count_clr", edge_count, 32'h0005_0100);
        chk("t5_count_narrow", 32'(ec2), 32'h34);
        clr = 4'b0;

        // Detection disabled: level tracks, nothing else changes
        mode = 2'b11;
        signal = 4'b0;
        tick(8);
        chk("t6_dis_level", 32'(level), 32'h0);
        chk("t6_dis_count", edge_count, 32'h0005_0100);
        chk("t6_dis_sticky", 32'(edge_sticky), 32'h6);

        // Reset while channel 3 is pending
        mode = 2'b00;
        signal[3] = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_edge", 32'(edge_detect), 32'h0);
        chk("t7_rst_sticky", 32'(edge_sticky), 32'h0);
        chk("t7_rst_count", edge_count, 32'h0);
        chk("t7_rst_level", 32'(level), 32'h0);
        signal[3] = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("t7_low_level", 32'(level), 32'h0);
        chk("t7_low_count", edge_count, 32'h0);

        // Channel high across reset release rises after normal latency
        signal[3] = 1'b1;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1; expect_pulse(4'b1000);
        tick(8);
        chk("t8_level", 32'(level), 32'h8);
        chk("t8_count", edge_count, 32'h0100_0000);
        chk("t8_sticky", 32'(edge_sticky), 32'h8);

        tick(5);
        chk("missing_pulses", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
